// File: rtl/e1of2_pkg.sv
// rtl/e1of2_pkg.sv - shared state type, flit width and dual-rail encoder for the e1of2 transmitter
package e1of2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RTZ  = 2'd2
  } tx_state_t;

  localparam int E1OF2_FLIT_W = 10;

  // Returns {true rails, false rails}; every pair comes out exactly one-hot.
  function automatic logic [2*E1OF2_FLIT_W-1:0] dr_encode(input logic [E1OF2_FLIT_W-1:0] word);
    return {word, ~word};
  endfunction

endpackage

// File: rtl/e1of2_sync.sv
// rtl/e1of2_sync.sv - N-flop synchronizer, async active-high reset to 0
module e1of2_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/e1of2_tx.sv
// rtl/e1of2_tx.sv - clocked valid/ready to e1of2 dual-rail four-phase transmitter
// Optional handshake-timeout flag built only with E1OF2_TX_TIMEOUT_EN.
module e1of2_tx
  import e1of2_pkg::*;
#(
  parameter int W           = E1OF2_FLIT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_d0,
  output logic [W-1:0] out_d1,
  input  logic         out_e,
  output logic         tx_err
);

  tx_state_t      state_q, state_d;
  logic [W-1:0]   d0_q, d0_d, d1_q, d1_d;
  logic           e_s;
  logic [2*W-1:0] enc;

  e1of2_sync #(.N(SYNC_STAGES)) u_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (out_e),
    .q_o   (e_s)
  );

  if (W == E1OF2_FLIT_W) begin : g_enc_pkg
    assign enc = dr_encode(in_data);
  end else begin : g_enc_gen
    assign enc = {in_data, ~in_data};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  // Rails default to null; only an accept loads them and only DATA holds them.
  always_comb begin
    state_d  = state_q;
    d0_d     = '0;
    d1_d     = '0;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = e_s;
        if (in_valid && e_s) begin
          state_d      = DATA;
          {d1_d, d0_d} = enc;
        end
      end
      DATA: begin
        if (e_s) begin
          d0_d = d0_q;
          d1_d = d1_q;
        end else begin
          state_d = RTZ;
        end
      end
      RTZ: begin
        if (e_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_d0 = d0_q;
  assign out_d1 = d1_q;

`ifdef E1OF2_TX_TIMEOUT_EN
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE && state_d == DATA) begin
      cnt_d = '0;
    end else if (state_q == DATA && cnt_q != T_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == DATA && cnt_d == T_MAX) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign tx_err = err_q;
`else
  // Constant 0: TIMEOUT only sizes the counter of the timeout build.
  assign tx_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_e1of2_tx.sv
// tb/tb_e1of2_tx.sv - self-checking bench for e1of2_tx with an asynchronous receiver model
module tb_e1of2_tx;

  localparam int W  = 10;
  localparam int SS = 2;
  localparam int TO = 15;
  localparam logic [W-1:0] ALL = '1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_d0;
  logic [W-1:0] out_d1;
  logic         out_e;
  logic         tx_err;

  int total = 0;
  int bad   = 0;

  bit           rx_auto = 1'b0;
  bit           rx_busy = 1'b0;
  bit           mon_en  = 1'b0;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] sent_q[$];

  e1of2_tx #(.W(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_d0   (out_d0),
    .out_d1   (out_d1),
    .out_e    (out_e),
    .tx_err   (tx_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rail pairs must never be 11, and the channel is either all-null or a full codeword.
  always @(negedge CLK) begin
    if (mon_en && !RESET) begin
      check("pair_overlap", out_d0 & out_d1, '0);
      check("codeword", ((out_d0 | out_d1) == '0) || (out_d0 == ~out_d1), 1);
    end
  end

  // Receiver: consume a complete codeword, drop enable, wait for null, raise enable.
  initial begin
    forever begin
      wait (rx_auto && ((out_d0 | out_d1) == ALL));
      rx_busy = 1'b1;
      rx_q.push_back(out_d1);
      #($urandom_range(0, 20));
      out_e = 1'b0;
      wait ((out_d0 | out_d1) == '0);
      #($urandom_range(0, 20));
      out_e = 1'b1;
      rx_busy = 1'b0;
    end
  end

  // Called at a negedge; waits for in_ready, then checks the codeword one clock after acceptance.
  task automatic send(input logic [W-1:0] w);
    bit           ok = 1'b0;
    logic [W-1:0] nw;
    nw       = ~w;
    in_data  = w;
    in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("accept", ok, 1);
    if (ok) begin
      @(posedge CLK);
      #1;
      sent_q.push_back(w);
      check("rail_d1", out_d1, w);
      check("rail_d0", out_d0, nw);
      check("ready_low_in_data", in_ready, 0);
      @(negedge CLK);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
  endtask

  task automatic finish_handshake(input string tag);
    bit ok = 1'b0;
    out_e = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      if ((out_d0 | out_d1) == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_null"}, ok, 1);
    out_e = 1'b1;
    wait_ready({tag, "_ready"});
  endtask

  // With SS synchronizer flops, e_s follows out_e SS clocks later; in_ready follows e_s in IDLE.
  task automatic release_and_check(input string tag);
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 1; k <= SS; k++) begin
      @(posedge CLK);
      #1;
      check({tag, "_ready"}, in_ready, (k == SS));
      check({tag, "_null"}, out_d0 | out_d1, '0);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    out_e    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_d0", out_d0, '0);
    check("rst_d1", out_d1, '0);
    check("rst_err", tx_err, 0);
    repeat (2) @(negedge CLK);
    release_and_check("por");
    mon_en = 1'b1;

    // Single flit, receiver driven by hand to pin down the handshake timing.
    @(negedge CLK);
    send(10'h2A5);
    in_valid = 1'b0;
    in_data  = 10'h15A;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check("hold_d1", out_d1, 10'h2A5);
      check("hold_d0", out_d0, 10'h15A);
    end
    @(negedge CLK);
    out_e = 1'b0;
    for (int k = 1; k <= SS + 1; k++) begin
      @(posedge CLK);
      #1;
      check("fall_d1", out_d1, (k <= SS) ? 10'h2A5 : 10'h000);
      check("fall_d0", out_d0, (k <= SS) ? 10'h15A : 10'h000);
    end
    @(negedge CLK);
    out_e = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      @(posedge CLK);
      #1;
      check("rise_ready", in_ready, (k == SS + 1));
    end

    // Random stream through the asynchronous receiver, in_valid held high.
    sent_q.delete();
    rx_q.delete();
    rx_auto = 1'b1;
    @(negedge CLK);
    for (int n = 0; n < 8; n++) send(W'($urandom));
    in_valid = 1'b0;
    for (int c = 0; c < 500 && (rx_q.size() < 8 || rx_busy); c++) @(negedge CLK);
    check("stream_count", rx_q.size(), 8);
    for (int n = 0; n < 8 && n < rx_q.size(); n++) check("stream_word", rx_q[n], sent_q[n]);
    check("stream_err", tx_err, 0);
    rx_auto = 1'b0;
    wait_ready("stream_idle");

    // Enable held low: nothing may be accepted until it rises.
    out_e = 1'b0;
    repeat (SS + 1) @(negedge CLK);
    in_data  = 10'h3FF;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("elow_ready", in_ready, 0);
      check("elow_null", out_d0 | out_d1, '0);
    end
    out_e = 1'b1;
    for (int k = 1; k <= SS; k++) begin
      @(posedge CLK);
      #1;
      check("erise_ready", in_ready, (k == SS));
    end
    @(posedge CLK);
    #1;
    check("erise_d1", out_d1, 10'h3FF);
    check("erise_d0", out_d0, 10'h000);
    @(negedge CLK);
    in_valid = 1'b0;
    finish_handshake("erise");

`ifdef E1OF2_TX_TIMEOUT_EN
    // Receiver never drops enable: flag rises after TO clocks in DATA and sticks.
    send(10'h155);
    in_valid = 1'b0;
    for (int k = 1; k <= TO + 5; k++) begin
      @(posedge CLK);
      #1;
      check("timeout_err", tx_err, (k >= TO));
    end
    @(negedge CLK);
    finish_handshake("timeout");
    check("timeout_sticky", tx_err, 1);
`endif

    // Reset in the middle of DATA: rails clear without a clock edge.
    send(10'h001);
    in_valid = 1'b0;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_d0", out_d0, '0);
    check("midrst_d1", out_d1, '0);
    check("midrst_ready", in_ready, 0);
    check("midrst_err", tx_err, 0);
    repeat (2) @(negedge CLK);
    release_and_check("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
